// File: rtl/vga_pattern_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pattern_gen_if
//  Description : Video bundle between the pattern generator and the VGA DAC.
//                Carries the frame-sampled mode/colour controls and the
//                registered video outputs (RGB, syncs, DE, coordinates).
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_pattern_gen_if #(
    parameter int COLOR_BITS = 1,
    parameter int XW         = 10,
    parameter int YW         = 10
);
    logic [2:0]              in_mode;
    logic [3*COLOR_BITS-1:0] in_color;
    logic [3*COLOR_BITS-1:0] ou_dispRGB;
    logic                    ou_Hsync;
    logic                    ou_Vsync;
    logic                    ou_active;
    logic [XW-1:0]           ou_x;
    logic [YW-1:0]           ou_y;
    logic                    ou_pix_en;
    logic                    ou_frame_start;

    // Generator side: consumes controls, produces video
    modport master (
        input  in_mode, in_color,
        output ou_dispRGB, ou_Hsync, ou_Vsync, ou_active,
               ou_x, ou_y, ou_pix_en, ou_frame_start
    );

    // Display / controller side
    modport slave (
        output in_mode, in_color,
        input  ou_dispRGB, ou_Hsync, ou_Vsync, ou_active,
               ou_x, ou_y, ou_pix_en, ou_frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pattern_gen
//  Description : Parametrised VGA timing and test-pattern generator. Divides
//                the system clock down to the pixel rate, runs the H/V raster
//                counters and renders one of eight frame-synchronous patterns.
//                All video outputs are registered on pixel-enable cycles so
//                RGB, syncs, DE and coordinates always describe one pixel.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_pattern_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int COLOR_BITS = 1,
    parameter int CLK_DIV    = 2,
    parameter int CHECK_LOG2 = 4
) (
    input  wire logic         in_clock_50MHz,
    input  wire logic         in_reset_n,
    vga_pattern_gen_if.master vif
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int unsigned C_H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned C_V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int          XW         = $clog2(C_H_TOTAL);
    localparam int          YW         = $clog2(C_V_TOTAL);
    localparam int          XP         = XW + 1;
    localparam int          CW         = 3 * COLOR_BITS;
    localparam int unsigned C_HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned C_HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int unsigned C_VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned C_VS_END   = V_VISIBLE + V_FRONT + V_SYNC;
    // Bar pitch; tiny rasters (fewer than 8 visible pixels) fall back to 1
    localparam int unsigned C_BAR_W    = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;
    localparam int unsigned C_BAR_H    = (V_VISIBLE / 8 > 0) ? V_VISIBLE / 8 : 1;
    localparam int unsigned C_BAND_W   = 16;
    localparam int unsigned C_BAND_STEP = 4;
    localparam int          C_DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // ------------------------------------------------------------------------
    // Pixel-rate divider
    // ------------------------------------------------------------------------
    logic w_pe;

    generate
        if (CLK_DIV > 1) begin : g_div
            logic [C_DW-1:0] r_div;

            // Count system clocks within one pixel period
            always_ff @(posedge in_clock_50MHz or negedge in_reset_n) begin
                if (!in_reset_n) begin
                    r_div <= '0;
                end else if (r_div == C_DW'(CLK_DIV - 1)) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + C_DW'(1);
                end
            end

            assign w_pe = (r_div == C_DW'(CLK_DIV - 1));
        end else begin : g_nodiv
            assign w_pe = 1'b1;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------------
    logic [XW-1:0] r_hc;
    logic [YW-1:0] r_vc;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_frame_end;

    assign w_h_last    = (r_hc == XW'(C_H_TOTAL - 1));
    assign w_v_last    = (r_vc == YW'(C_V_TOTAL - 1));
    assign w_frame_end = w_pe & w_h_last & w_v_last;

    // Advance the horizontal count each pixel, vertical count at line wrap
    always_ff @(posedge in_clock_50MHz or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_pe) begin
            if (w_h_last) begin
                r_hc <= '0;
                r_vc <= w_v_last ? '0 : r_vc + YW'(1);
            end else begin
                r_hc <= r_hc + XW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame-boundary state: mode, colour and moving-band origin
    // ------------------------------------------------------------------------
    logic [2:0]    r_mode;
    logic [CW-1:0] r_color;
    logic [XW-1:0] r_pos;
    logic [XW:0]   w_pos_inc;
    logic          w_pos_wrap;

    // One extra bit so pos+4 cannot overflow before the wrap compare
    assign w_pos_inc  = {1'b0, r_pos} + XP'(C_BAND_STEP);
    assign w_pos_wrap = (32'(w_pos_inc) >= 32'(H_VISIBLE));

    // Latch controls and step the band only on the last pixel of a frame
    always_ff @(posedge in_clock_50MHz or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_mode  <= 3'd0;
            r_color <= '0;
            r_pos   <= '0;
        end else if (w_frame_end) begin
            r_mode  <= vif.in_mode;
            r_color <= vif.in_color;
            r_pos   <= w_pos_wrap ? '0 : w_pos_inc[XW-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // Pattern rendering for the current (hc, vc)
    // ------------------------------------------------------------------------
    logic [2:0]    w_idx_h;
    logic [2:0]    w_idx_v;
    logic          w_chk;
    logic          w_band;
    logic          w_active;
    logic          w_hs_on;
    logic          w_vs_on;
    logic [2:0]    w_idx;
    logic [CW-1:0] w_pix;

    // Bars count down from white (index 7) to black, clamped past bar 7
    assign w_idx_h = (32'(r_hc) / C_BAR_W >= 32'd7) ? 3'd0
                   : 3'd7 - 3'(32'(r_hc) / C_BAR_W);
    assign w_idx_v = (32'(r_vc) / C_BAR_H >= 32'd7) ? 3'd0
                   : 3'd7 - 3'(32'(r_vc) / C_BAR_H);

    assign w_chk  = |(((32'(r_hc) ^ 32'(r_vc)) >> CHECK_LOG2) & 32'd1);
    assign w_band = (32'(r_hc) >= 32'(r_pos)) &&
                    (32'(r_hc) <  32'(r_pos) + C_BAND_W);

    assign w_active = (32'(r_hc) < 32'(H_VISIBLE)) && (32'(r_vc) < 32'(V_VISIBLE));
    assign w_hs_on  = (32'(r_hc) >= C_HS_START) && (32'(r_hc) < C_HS_END);
    assign w_vs_on  = (32'(r_vc) >= C_VS_START) && (32'(r_vc) < C_VS_END);

    // Select the 3-bit colour index for the latched mode
    always_comb begin
        w_idx = 3'd0;
        case (r_mode)
            3'd0:    w_idx = w_idx_h;
            3'd1:    w_idx = w_idx_v;
            3'd2:    w_idx = w_idx_h ^ w_idx_v;
            3'd3:    w_idx = ~(w_idx_h ^ w_idx_v);
            3'd4:    w_idx = {3{w_chk}};
            3'd6:    w_idx = {3{w_band}};
            default: w_idx = 3'd0;
        endcase
    end

    // Expand the index to full channels; solid mode bypasses the index
    always_comb begin
        w_pix = {{COLOR_BITS{w_idx[2]}}, {COLOR_BITS{w_idx[1]}}, {COLOR_BITS{w_idx[0]}}};
        if (r_mode == 3'd5) begin
            w_pix = r_color;
        end
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    logic [CW-1:0] r_rgb;
    logic          r_hs;
    logic          r_vs;
    logic          r_act;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_pix_en;
    logic          r_fs;

    // Register all per-pixel outputs together on pixel-enable cycles
    always_ff @(posedge in_clock_50MHz or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_rgb <= '0;
            r_hs  <= ~SYNC_POL;
            r_vs  <= ~SYNC_POL;
            r_act <= 1'b0;
            r_x   <= '0;
            r_y   <= '0;
        end else if (w_pe) begin
            r_rgb <= w_active ? w_pix : '0;
            r_hs  <= w_hs_on ? SYNC_POL : ~SYNC_POL;
            r_vs  <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            r_act <= w_active;
            r_x   <= r_hc;
            r_y   <= r_vc;
        end
    end

    // Strobes: pixel enable delayed one clock, frame start at pixel (0,0)
    always_ff @(posedge in_clock_50MHz or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_pix_en <= 1'b0;
            r_fs     <= 1'b0;
        end else begin
            r_pix_en <= w_pe;
            r_fs     <= w_pe && (r_hc == '0) && (r_vc == '0);
        end
    end

    assign vif.ou_dispRGB     = r_rgb;
    assign vif.ou_Hsync       = r_hs;
    assign vif.ou_Vsync       = r_vs;
    assign vif.ou_active      = r_act;
    assign vif.ou_x           = r_x;
    assign vif.ou_y           = r_y;
    assign vif.ou_pix_en      = r_pix_en;
    assign vif.ou_frame_start = r_fs;

endmodule
`default_nettype wire
